// File: rtl/string_pkg.sv
// string_pkg: ASCII constants, state encoding and default sizes
// shared by string_assembler and string_preprocess.
package string_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int STRLEN_DEF = 32;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_NL    = 8'h0A;

    typedef enum logic [1:0] {
        INIT,
        COLLECT,
        DISCARD,
        HOLD
    } state_t;

endpackage

// File: rtl/string_assembler_if.sv
// string_assembler_if: byte-stream input handshake plus the
// assembled-line output bundle of the string assembler.
interface string_assembler_if
    import string_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int STRLEN = STRLEN_DEF
);

    logic [DWIDTH-1:0]        byte_in;
    logic                     byte_valid;
    logic                     byte_ready;
    logic [STRLEN*DWIDTH-1:0] in_string;
    logic                     string_valid;
    logic                     string_ack;
    logic [5:0]               char_count;
    logic                     err_char;
    logic                     err_overflow;

    modport master (
        output byte_in, byte_valid, string_ack,
        input  byte_ready, in_string, string_valid,
        input  char_count, err_char, err_overflow
    );

    modport slave (
        input  byte_in, byte_valid, string_ack,
        output byte_ready, in_string, string_valid,
        output char_count, err_char, err_overflow
    );

endinterface

// File: rtl/ascii_char_class.sv
// ascii_char_class: combinational classifier for one incoming
// character (digit / space / line terminator / illegal).
module ascii_char_class
    import string_pkg::*;
#(
    parameter int         DWIDTH    = DWIDTH_DEF,
    parameter logic [7:0] TERM_CHAR = CH_NL
) (
    input  logic [DWIDTH-1:0] ch,
    output logic              is_digit,
    output logic              is_space,
    output logic              is_term,
    output logic              is_illegal
);

    // classify the character; exactly one flag is set
    always_comb begin
        is_digit   = (ch >= DWIDTH'(CH_ZERO)) &&
                     (ch <= DWIDTH'(CH_NINE));
        is_space   = (ch == DWIDTH'(CH_SPACE));
        is_term    = (ch == DWIDTH'(TERM_CHAR));
        is_illegal = !(is_digit || is_space || is_term);
    end

endmodule

// File: rtl/string_assembler.sv
// string_assembler: collects ASCII digits/spaces into a right-aligned,
// '0'-padded line held until acked. Option: STRASM_SPACE_COLLAPSE_EN.
module string_assembler
    import string_pkg::*;
#(
    parameter int         DWIDTH    = DWIDTH_DEF,
    parameter int         in_strlen = STRLEN_DEF,
    parameter logic [7:0] TERM_CHAR = CH_NL
) (
    input logic clk,
    input logic reset,
    string_assembler_if.slave bus
);

    localparam int                W       = in_strlen * DWIDTH;
    localparam logic [5:0]        CNT_MAX = 6'(in_strlen);
    localparam logic [DWIDTH-1:0] ZERO    = DWIDTH'(CH_ZERO);
    localparam logic [DWIDTH-1:0] SPACE   = DWIDTH'(CH_SPACE);
    localparam logic [W-1:0]      FILL    = {in_strlen{ZERO}};

`ifdef STRASM_SPACE_COLLAPSE_EN
    localparam bit COLLAPSE = 1'b1;
`else
    localparam bit COLLAPSE = 1'b0;
`endif

    state_t            state, state_n;
    logic [W-1:0]      line, line_n;
    logic [5:0]        count, count_n;
    logic              err, err_n;
    logic              ovf, ovf_n;
    logic              trim, trim_n;
    logic              ready, accept, store;
    logic [DWIDTH-1:0] ch;
    logic              is_digit, is_space, is_term, is_illegal;

    ascii_char_class #(
        .DWIDTH    (DWIDTH),
        .TERM_CHAR (TERM_CHAR)
    ) u_class (
        .ch         (bus.byte_in),
        .is_digit   (is_digit),
        .is_space   (is_space),
        .is_term    (is_term),
        .is_illegal (is_illegal)
    );

    // a pending trailing-space trim blocks input for one cycle
    assign ready  = ((state == COLLECT) || (state == DISCARD)) && !trim;
    assign accept = bus.byte_valid && ready;

    assign bus.byte_ready   = ready;
    assign bus.in_string    = line;
    assign bus.string_valid = (state == HOLD);
    assign bus.char_count   = count;
    assign bus.err_char     = err;
    assign bus.err_overflow = ovf;

    // state register and line buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            line  <= FILL;
            count <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
            trim  <= 1'b0;
        end else begin
            state <= state_n;
            line  <= line_n;
            count <= count_n;
            err   <= err_n;
            ovf   <= ovf_n;
            trim  <= trim_n;
        end
    end

    // next state, buffer insertion, error flags
    always_comb begin
        state_n = state;
        line_n  = line;
        count_n = count;
        err_n   = err;
        ovf_n   = 1'b0;
        trim_n  = trim;
        store   = 1'b0;
        ch      = (is_digit || is_space) ? bus.byte_in : SPACE;
        unique case (state)
            INIT: begin
                state_n = COLLECT;
            end
            COLLECT: begin
                if (trim) begin
                    // drop the trailing space, shifting padding in on top
                    line_n  = {ZERO, line[W-1:DWIDTH]};
                    count_n = count - 6'd1;
                    trim_n  = 1'b0;
                    state_n = (count == 6'd1) ? COLLECT : HOLD;
                end else if (accept) begin
                    if (is_term) begin
                        if (count != '0) begin
                            if (COLLAPSE && line[DWIDTH-1:0] == SPACE)
                                trim_n = 1'b1;
                            else
                                state_n = HOLD;
                        end
                    end else if (count == CNT_MAX) begin
                        state_n = DISCARD;
                    end else begin
                        store = 1'b1;
                        if (is_illegal)
                            err_n = 1'b1;
                        if (COLLAPSE && ch == SPACE &&
                            (count == '0 || line[DWIDTH-1:0] == SPACE))
                            store = 1'b0;
                        if (store) begin
                            line_n  = {line[W-DWIDTH-1:0], ch};
                            count_n = count + 6'd1;
                        end
                    end
                end
            end
            DISCARD: begin
                if (accept && is_term) begin
                    ovf_n   = 1'b1;
                    line_n  = FILL;
                    count_n = '0;
                    err_n   = 1'b0;
                    state_n = COLLECT;
                end
            end
            HOLD: begin
                if (bus.string_ack) begin
                    line_n  = FILL;
                    count_n = '0;
                    err_n   = 1'b0;
                    state_n = COLLECT;
                end
            end
        endcase
    end

endmodule
